// File: rtl/map_arb_pkg.sv
// map_arb_pkg: shared constants, pipeline tag type and address packing for the map port arbiter.
package map_arb_pkg;
    localparam int MAP_W = 6;
    localparam int ADDR_W = 2 * MAP_W;
    localparam int CL_TANK1 = 0;
    localparam int CL_TANK2 = 1;
    localparam int CL_SHELL = 2;
    typedef enum logic [2:0] {NONE, VGA, CLI0, CLI1, CLI2} pipe_tag_t;
    function automatic logic [ADDR_W-1:0] pack_addr(input logic [MAP_W-1:0] y, input logic [MAP_W-1:0] x);
        return {y, x};
    endfunction
endpackage

// File: rtl/map_port_arbiter_if.sv
// map_port_arbiter_if: VGA, client and memory-side signals of the map port arbiter.
interface map_port_arbiter_if #(
    parameter int MAP_W = 6,
    parameter int N_CLI = 3
);
    logic                   i_vga_req;
    logic [MAP_W-1:0]       i_vga_x, i_vga_y;
    logic                   o_vga_valid, o_vga_wall;
    logic [N_CLI-1:0]       i_req, i_we, i_wdata, o_gnt, o_rvalid;
    logic [N_CLI*MAP_W-1:0] i_x, i_y;
    logic                   o_rdata, o_starve;
    logic [2*MAP_W-1:0]     o_mem_addr;
    logic                   o_mem_we, o_mem_wdata, i_mem_rdata;
    modport slave (
        input  i_vga_req, i_vga_x, i_vga_y, i_req, i_we, i_wdata, i_x, i_y, i_mem_rdata,
        output o_vga_valid, o_vga_wall, o_gnt, o_rvalid, o_rdata, o_starve, o_mem_addr, o_mem_we, o_mem_wdata
    );
    modport master (
        output i_vga_req, i_vga_x, i_vga_y, i_req, i_we, i_wdata, i_x, i_y, i_mem_rdata,
        input  o_vga_valid, o_vga_wall, o_gnt, o_rvalid, o_rdata, o_starve, o_mem_addr, o_mem_we, o_mem_wdata
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant searching from ptr_i, suppressed entirely by block_i.
module rr_arbiter #(
    parameter int N = 3,
    localparam int PW = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic          block_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] ptr_nxt_o
);
    int   idx;
    logic found;
    always_comb begin
        gnt_o = '0;
        ptr_nxt_o = ptr_i;
        found = 1'b0;
        idx = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && !block_i && req_i[idx]) begin
                found = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_nxt_o = PW'((idx + 1) % N);
            end
        end
    end
endmodule

// File: rtl/map_port_arbiter.sv
// map_port_arbiter: shares the single-port wall map between the VGA renderer (absolute priority)
// and round-robin clients, with a fixed three-cycle read latency for everyone.
module map_port_arbiter #(
    parameter int MAP_W = 6,
    parameter int N_CLI = 3,
    parameter int WAIT_MAX = 255
) (
    input logic clk,
    input logic rst_n,
    map_port_arbiter_if.slave bus
);
    import map_arb_pkg::*;
    localparam int PW = N_CLI > 1 ? $clog2(N_CLI) : 1;
    function automatic pipe_tag_t tag_of(input int k);
        return k == CL_TANK1 ? CLI0 : k == CL_TANK2 ? CLI1 : k == CL_SHELL ? CLI2 : NONE;
    endfunction
    logic [PW-1:0]      ptr_q, ptr_d, g;
    logic [N_CLI-1:0]   gnt, rvalid_q, rvalid_d;
    logic [2*MAP_W-1:0] addr_q, addr_d;
    logic               we_q, we_d, wd_q, wd_d, rd1_q, rd1_d, rd2_q;
    pipe_tag_t          tag1_q, tag1_d, tag2_q;
    logic               vga_valid_q, vga_wall_q, rdata_q, starve_q, starve_d;
    logic [7:0]         cnt_q, cnt_d;
    rr_arbiter #(.N(N_CLI)) u_rr (
        .req_i(bus.i_req), .block_i(bus.i_vga_req), .ptr_i(ptr_q), .gnt_o(gnt), .ptr_nxt_o(ptr_d)
    );
    always_comb begin
        g = '0;
        for (int k = 0; k < N_CLI; k++) if (gnt[k]) g = PW'(k);
        addr_d = addr_q;
        we_d = 1'b0;
        wd_d = wd_q;
        tag1_d = NONE;
        rd1_d = 1'b0;
        if (bus.i_vga_req) begin
            addr_d = pack_addr(bus.i_vga_y, bus.i_vga_x);
            tag1_d = VGA;
            rd1_d = 1'b1;
        end else if (|gnt) begin
            addr_d = pack_addr(bus.i_y[int'(g)*MAP_W +: MAP_W], bus.i_x[int'(g)*MAP_W +: MAP_W]);
            we_d = bus.i_we[g];
            wd_d = bus.i_wdata[g];
            tag1_d = tag_of(int'(g));
            rd1_d = !bus.i_we[g];
        end
        // a client is starving only while it waits without any grant going out
        cnt_d = |gnt ? 8'd0 : (|bus.i_req && cnt_q < 8'(WAIT_MAX)) ? cnt_q + 8'd1 : cnt_q;
        starve_d = starve_q | (cnt_d == 8'(WAIT_MAX));
        for (int k = 0; k < N_CLI; k++) rvalid_d[k] = rd2_q && tag2_q == tag_of(k);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
            addr_q <= '0;
            we_q <= 1'b0;
            wd_q <= 1'b0;
            tag1_q <= NONE;
            rd1_q <= 1'b0;
            tag2_q <= NONE;
            rd2_q <= 1'b0;
            vga_valid_q <= 1'b0;
            vga_wall_q <= 1'b0;
            rvalid_q <= '0;
            rdata_q <= 1'b0;
            cnt_q <= '0;
            starve_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            addr_q <= addr_d;
            we_q <= we_d;
            wd_q <= wd_d;
            tag1_q <= tag1_d;
            rd1_q <= rd1_d;
            tag2_q <= tag1_q;
            rd2_q <= rd1_q;
            vga_valid_q <= rd2_q && tag2_q == VGA;
            vga_wall_q <= (rd2_q && tag2_q == VGA) ? bus.i_mem_rdata : vga_wall_q;
            rvalid_q <= rvalid_d;
            rdata_q <= |rvalid_d ? bus.i_mem_rdata : rdata_q;
            cnt_q <= cnt_d;
            starve_q <= starve_d;
        end
    end
    assign bus.o_gnt = gnt;
    assign bus.o_rvalid = rvalid_q;
    assign bus.o_rdata = rdata_q;
    assign bus.o_vga_valid = vga_valid_q;
    assign bus.o_vga_wall = vga_wall_q;
    assign bus.o_starve = starve_q;
    assign bus.o_mem_addr = addr_q;
    assign bus.o_mem_we = we_q;
    assign bus.o_mem_wdata = wd_q;
endmodule
